rf_spi_ctrl: RTL



---
 rtl/rf_cfg_pkg.sv | 25 ++
 rtl/rf_spi_shifter.sv | 89 ++++++++
 rtl/rf_spi_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/rf_cfg_pkg.sv
// Shared configuration for the RF synthesizer SPI path: FSM states,
// default word geometry and timing constants used by the table block too.
package rf_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_LATCH,
        S_ADV,
        S_DONE
    } state_t;

    localparam int WORD_W_DEF    = 24;
    localparam int NUM_WORDS_DEF = 6;
    localparam int CLK_DIV_DEF   = 4;
    localparam int LE_CYCLES_DEF = 2;
    localparam int LOAD_WAIT_DEF = 2;

    // Width of a counter that must hold values 0..max_val (never below 1 bit)
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rf_spi_shifter.sv
// SPI bit engine: SCLK divider, bit counter and MSB-first shift register.
// A load pulse starts one word; o_last pulses once when SCLK has fallen
// after the final bit. Data only changes while SCLK is low.
module rf_spi_shifter
    import rf_cfg_pkg::*;
#(
    parameter int WORD_W  = WORD_W_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic              clk,
    input  logic              RSTn,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_last,
    output logic              o_sclk,
    output logic              o_data
);

    localparam int BW = cnt_w(WORD_W);
    localparam int DW = cnt_w(CLK_DIV);

    logic [WORD_W-1:0] r_sreg;
    logic [BW-1:0]     r_bit_cnt;
    logic [DW-1:0]     r_div_cnt;
    logic              r_phase;
    logic              r_active;
    logic              r_sclk;
    logic              r_data;
    logic              r_last;

    // Half-period divider; the high phase ends with SCLK falling and a shift
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_sreg    <= '0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_phase   <= 1'b0;
            r_active  <= 1'b0;
            r_sclk    <= 1'b0;
            r_data    <= 1'b0;
            r_last    <= 1'b0;
        end else begin
            r_last <= 1'b0;
            if (i_abort) begin
                r_active <= 1'b0;
                r_sclk   <= 1'b0;
                r_data   <= 1'b0;
            end else if (i_load) begin
                r_sreg    <= i_word;
                r_bit_cnt <= BW'(WORD_W);
                r_div_cnt <= '0;
                r_phase   <= 1'b0;
                r_active  <= 1'b1;
                r_sclk    <= 1'b0;
                r_data    <= i_word[WORD_W-1];
            end else if (r_active) begin
                if (r_div_cnt == DW'(CLK_DIV - 1)) begin
                    r_div_cnt <= '0;
                    if (!r_phase) begin
                        r_phase <= 1'b1;
                        r_sclk  <= 1'b1;
                    end else begin
                        r_phase   <= 1'b0;
                        r_sclk    <= 1'b0;
                        r_sreg    <= {r_sreg[WORD_W-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt - BW'(1);
                        if (r_bit_cnt == BW'(1)) begin
                            r_active <= 1'b0;
                            r_data   <= 1'b0;
                            r_last   <= 1'b1;
                        end else begin
                            r_data <= r_sreg[WORD_W-2];
                        end
                    end
                end else begin
                    r_div_cnt <= r_div_cnt + DW'(1);
                end
            end
        end
    end

    assign o_busy = r_active;
    assign o_last = r_last;
    assign o_sclk = r_sclk;
    assign o_data = r_data;

endmodule

// File: rtl/rf_spi_ctrl.sv
// Sequencing SPI master: pulls NUM_WORDS words from the register table,
// shifts each out on SCLK/DATA, closes it with an LE pulse and steps the
// table with word_adv between words (never past the last one).
module rf_spi_ctrl
    import rf_cfg_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int NUM_WORDS = NUM_WORDS_DEF,
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int LE_CYCLES = LE_CYCLES_DEF,
    parameter int LOAD_WAIT = LOAD_WAIT_DEF
) (
    input  logic                             clk,
    input  logic                             RSTn,
    input  logic                             start,
    input  logic                             abort,
    input  logic [WORD_W-1:0]                word_in,
    output logic                             word_adv,
    output logic                             spi_sclk,
    output logic                             spi_data,
    output logic                             spi_le,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(NUM_WORDS+1)-1:0]   word_idx
);

    localparam int IW = $clog2(NUM_WORDS + 1);
    localparam int LW = cnt_w(LOAD_WAIT);
    localparam int EW = cnt_w(LE_CYCLES);

    state_t        r_state;
    logic [LW-1:0] r_load_cnt;
    logic [EW-1:0] r_le_cnt;
    logic [IW-1:0] r_word_idx;
    logic          r_word_adv;
    logic          r_le;
    logic          r_busy;
    logic          r_done;

    logic          w_load;
    logic          w_sh_busy;
    logic          w_sh_last;

    // Capture happens on the cycle the settle counter has run out
    assign w_load = (r_state == S_LOAD) && (r_load_cnt == '0) && !abort;

    rf_spi_shifter #(
        .WORD_W  (WORD_W),
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk     (clk),
        .RSTn    (RSTn),
        .i_load  (w_load),
        .i_word  (word_in),
        .i_abort (abort),
        .o_busy  (w_sh_busy),
        .o_last  (w_sh_last),
        .o_sclk  (spi_sclk),
        .o_data  (spi_data)
    );

    // Word sequencing FSM; abort drops straight to IDLE keeping word_idx
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= S_IDLE;
            r_load_cnt <= '0;
            r_le_cnt   <= '0;
            r_word_idx <= '0;
            r_word_adv <= 1'b0;
            r_le       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_word_adv <= 1'b0;
            r_done     <= 1'b0;
            if (abort && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_le    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            r_state    <= S_LOAD;
                            r_busy     <= 1'b1;
                            r_word_idx <= '0;
                            r_load_cnt <= '0;
                        end
                    end
                    S_LOAD: begin
                        if (r_load_cnt == '0) r_state <= S_SHIFT;
                        else                  r_load_cnt <= r_load_cnt - LW'(1);
                    end
                    S_SHIFT: begin
                        if (w_sh_last || !w_sh_busy) begin
                            r_state  <= S_LATCH;
                            r_le     <= 1'b1;
                            r_le_cnt <= EW'(LE_CYCLES - 1);
                        end
                    end
                    S_LATCH: begin
                        if (r_le_cnt == '0) begin
                            r_le       <= 1'b0;
                            r_word_idx <= r_word_idx + IW'(1);
                            r_state    <= S_ADV;
                        end else begin
                            r_le_cnt <= r_le_cnt - EW'(1);
                        end
                    end
                    S_ADV: begin
                        if (r_word_idx == IW'(NUM_WORDS)) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_word_adv <= 1'b1;
                            r_load_cnt <= LW'(LOAD_WAIT);
                            r_state    <= S_LOAD;
                        end
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign word_adv = r_word_adv;
    assign spi_le   = r_le;
    assign busy     = r_busy;
    assign done     = r_done;
    assign word_idx = r_word_idx;

endmodule
